// File: rtl/umi_address_remap_pipe.sv
// -----------------------------------------------------------------------------
// umi_address_remap_pipe
//
// Registered UMI request-path address remapper with a 2-entry skid pipeline.
// The chip-ID field of dstaddr (bits [IDSB+IDW-1:IDSB]) is rewritten using a
// runtime-programmable NMAPS-entry table. Traffic addressed to the local chip
// that falls inside [win_low, win_high] is shifted by win_offset instead.
//
// Optional feature macro: UMI_ADDRESS_REMAP_SRCADDR_EN
//   When defined, the srcaddr chip-ID field is reverse-mapped (new -> old)
//   through the same table so that responses find their way back.
//
// Ports:
//   clk, nreset            clock, asynchronous active-low reset
//   chipid                 local chip ID
//   cfg_valid/idx/en/old/new  table write port (takes effect next cycle)
//   win_offset/low/high    local address window (inclusive, unsigned)
//   cnt_clear              synchronous clear of hit_count (beats increment)
//   hit_count              saturating count of remapped accepted beats
//   umi_in_*               request input (valid/ready)
//   umi_out_*              request output (valid/ready), registered
// -----------------------------------------------------------------------------
module umi_address_remap_pipe #(
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 256,
    parameter int IDW   = 16,
    parameter int IDSB  = 40,
    parameter int NMAPS = 8,
    parameter int CNTW  = 32,
    localparam int IW   = (NMAPS > 1) ? $clog2(NMAPS) : 1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [IDW-1:0]  chipid,
    input  logic            cfg_valid,
    input  logic [IW-1:0]   cfg_idx,
    input  logic            cfg_en,
    input  logic [IDW-1:0]  cfg_old,
    input  logic [IDW-1:0]  cfg_new,
    input  logic [AW-1:0]   win_offset,
    input  logic [AW-1:0]   win_low,
    input  logic [AW-1:0]   win_high,
    input  logic            cnt_clear,
    output logic [CNTW-1:0] hit_count,
    input  logic            umi_in_valid,
    input  logic [CW-1:0]   umi_in_cmd,
    input  logic [AW-1:0]   umi_in_dstaddr,
    input  logic [AW-1:0]   umi_in_srcaddr,
    input  logic [DW-1:0]   umi_in_data,
    output logic            umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready
);

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- table
    logic [NMAPS-1:0] en_q;
    logic [IDW-1:0]   old_q [NMAPS];
    logic [IDW-1:0]   new_q [NMAPS];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            en_q <= '0;
            for (int unsigned i = 0; i < NMAPS; i++) begin
                old_q[i] <= '0;
                new_q[i] <= '0;
            end
        end else if (cfg_valid && (int'(cfg_idx) < NMAPS)) begin
            en_q[cfg_idx]  <= cfg_en;
            old_q[cfg_idx] <= cfg_old;
            new_q[cfg_idx] <= cfg_new;
        end
    end

    // ---------------------------------------------------------------- remap
    logic [IDW-1:0] in_id;
    logic           tbl_match;
    logic [IDW-1:0] tbl_new;
    logic           win_hit;
    logic           tbl_hit;
    logic           remap_hit;
    beat_t          remap;

    always_comb begin
        in_id     = umi_in_dstaddr[IDSB+IDW-1:IDSB];
        tbl_match = 1'b0;
        tbl_new   = '0;
        // Ascending scan with a found flag: the lowest matching index wins.
        for (int unsigned i = 0; i < NMAPS; i++) begin
            if (!tbl_match && en_q[i] && (old_q[i] == in_id)) begin
                tbl_match = 1'b1;
                tbl_new   = new_q[i];
            end
        end

        win_hit   = (in_id == chipid) &&
                    (umi_in_dstaddr >= win_low) && (umi_in_dstaddr <= win_high);
        tbl_hit   = tbl_match && (in_id != chipid);
        remap_hit = win_hit || tbl_hit;

        remap.cmd  = umi_in_cmd;
        remap.dst  = umi_in_dstaddr;
        remap.src  = umi_in_srcaddr;
        remap.data = umi_in_data;

        if (win_hit) begin
            remap.dst = umi_in_dstaddr + win_offset;
        end else if (tbl_hit) begin
            remap.dst[IDSB+IDW-1:IDSB] = tbl_new;
        end
    end

`ifdef UMI_ADDRESS_REMAP_SRCADDR_EN
    logic [IDW-1:0] src_id;
    logic           src_match;
    logic [IDW-1:0] src_old;
    beat_t          remap_out;

    always_comb begin
        src_id    = umi_in_srcaddr[IDSB+IDW-1:IDSB];
        src_match = 1'b0;
        src_old   = '0;
        for (int unsigned i = 0; i < NMAPS; i++) begin
            if (!src_match && en_q[i] && (new_q[i] == src_id)) begin
                src_match = 1'b1;
                src_old   = old_q[i];
            end
        end
        remap_out = remap;
        if (src_match) begin
            remap_out.src[IDSB+IDW-1:IDSB] = src_old;
        end
    end
`else
    beat_t remap_out;

    always_comb begin
        remap_out = remap;
    end
`endif

    // ------------------------------------------------------------- pipeline
    state_t state_q, state_d;
    beat_t  out_q, out_d;
    beat_t  skid_q, skid_d;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   accept;
    logic   drain;

    assign accept = umi_in_valid & in_ready_q;
    assign drain  = out_valid_q & umi_out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = remap_out;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    out_d = remap_out;
                end else if (accept) begin
                    skid_d  = remap_out;
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Ready and valid are flopped from the next state so neither depends
    // combinationally on umi_out_ready.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign umi_in_ready    = in_ready_q;
    assign umi_out_valid   = out_valid_q;
    assign umi_out_cmd     = out_q.cmd;
    assign umi_out_dstaddr = out_q.dst;
    assign umi_out_srcaddr = out_q.src;
    assign umi_out_data    = out_q.data;

    // -------------------------------------------------------------- counter
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (accept && remap_hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_count = cnt_q;

endmodule
